// File: rtl/cyclic_lamp_ctrl.sv
// RGY signal-head sequencer: timed RED -> GREEN -> YELLOW cycle with pedestrian
// GREEN cut-short and a flashing-yellow fault/maintenance mode.
module cyclic_lamp_ctrl #(
  parameter int unsigned CW      = 8,
  parameter int unsigned RED_T   = 10,
  parameter int unsigned GRN_T   = 8,
  parameter int unsigned YEL_T   = 3,
  parameter int unsigned MIN_GRN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [0:2] light,
  output logic [1:0] phase,
  output logic       ped_ack
);

  localparam logic [CW-1:0] RED_LAST = CW'(RED_T - 1);
  localparam logic [CW-1:0] GRN_LAST = CW'(GRN_T - 1);
  localparam logic [CW-1:0] YEL_LAST = CW'(YEL_T - 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GRN - 1);

  typedef enum logic [1:0] {
    S_RED   = 2'b00,
    S_GRN   = 2'b01,
    S_YEL   = 2'b10,
    S_FLASH = 2'b11
  } state_t;

  state_t        state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic          ped_pend, npend;
  logic          flash_ph, nflash;
  logic          nack;
  logic [0:2]    nlight;

  // Next-state: priority is flash_en > ped-forced exit > expiry > count.
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    npend  = ped_pend;
    nflash = flash_ph;
    nack   = 1'b0;
    if (flash_en) begin
      nstate = S_FLASH;
      if (state != S_FLASH) begin
        ncnt   = '0;
        npend  = 1'b0;
        nflash = 1'b0;
      end else if (tick) begin
        nflash = ~flash_ph;
      end
    end else begin
      case (state)
        S_FLASH: begin
          nstate = S_RED;
          ncnt   = '0;
          npend  = 1'b0;
          nflash = 1'b0;
        end
        S_RED: begin
          if (tick) begin
            if (cnt == RED_LAST) begin
              nstate = S_GRN;
              ncnt   = '0;
            end else begin
              ncnt = cnt + CW'(1);
            end
          end
        end
        S_GRN: begin
          if (ped_req) npend = 1'b1;
          if (tick) begin
            if ((ped_pend && (cnt >= MIN_LAST)) || (cnt == GRN_LAST)) begin
              nstate = S_YEL;
              ncnt   = '0;
            end else begin
              ncnt = cnt + CW'(1);
            end
          end
        end
        default: begin
          if (ped_req) npend = 1'b1;
          if (tick) begin
            if (cnt == YEL_LAST) begin
              nstate = S_RED;
              ncnt   = '0;
              nack   = ped_pend;
              npend  = 1'b0;
            end else begin
              ncnt = cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

  // Lamp drive decoded from the upcoming state so it registers with it.
  always_comb begin
    nlight = 3'b100;
    case (nstate)
      S_RED:   nlight = 3'b100;
      S_GRN:   nlight = 3'b010;
      S_YEL:   nlight = 3'b001;
      default: nlight = nflash ? 3'b000 : 3'b001;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RED;
      cnt      <= '0;
      ped_pend <= 1'b0;
      flash_ph <= 1'b0;
      light    <= 3'b100;
      phase    <= 2'b00;
      ped_ack  <= 1'b0;
    end else begin
      state    <= nstate;
      cnt      <= ncnt;
      ped_pend <= npend;
      flash_ph <= nflash;
      light    <= nlight;
      phase    <= nstate;
      ped_ack  <= nack;
    end
  end

endmodule

// File: tb/tb_cyclic_lamp_ctrl.sv
// Self-checking bench for cyclic_lamp_ctrl: reference model feeds a scoreboard
// of per-clock expectations; scenario tasks add directed phase-length checks.
module tb_cyclic_lamp_ctrl;

  localparam int RED_T   = 10;
  localparam int GRN_T   = 8;
  localparam int YEL_T   = 3;
  localparam int MIN_GRN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash_en = 1'b0;
  logic [0:2] light;
  logic [1:0] phase;
  logic       ped_ack;

  cyclic_lamp_ctrl #(
    .CW(8), .RED_T(RED_T), .GRN_T(GRN_T), .YEL_T(YEL_T), .MIN_GRN(MIN_GRN)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .flash_en(flash_en),
    .light(light), .phase(phase), .ped_ack(ped_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:2] light;
    logic [1:0] phase;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   gk = 0;

  // Reference model: counts remaining ticks down rather than elapsed ticks up.
  int m_st = 0;
  int m_rem = RED_T;
  int m_el = 0;
  bit m_pend = 1'b0;
  bit m_fph = 1'b0;

  // Scoreboard consumer: one expectation per clock edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (light !== e.light) begin
        errors++;
        $display("FAIL sb_light t=%0t got %b want %b", $time, light, e.light);
      end
      checks++;
      if (phase !== e.phase) begin
        errors++;
        $display("FAIL sb_phase t=%0t got %b want %b", $time, phase, e.phase);
      end
      checks++;
      if (ped_ack !== e.ack) begin
        errors++;
        $display("FAIL sb_ped_ack t=%0t got %b want %b", $time, ped_ack, e.ack);
      end
    end
  end

  task automatic drive(input logic r, input logic t, input logic pr, input logic fe);
    exp_t e;
    bit   old;
    bit   ack;
    rst = r; tick = t; ped_req = pr; flash_en = fe;
    ack = 1'b0;
    if (r) begin
      m_st = 0; m_rem = RED_T; m_el = 0; m_pend = 0; m_fph = 0;
    end else if (fe) begin
      if (m_st != 3) begin
        m_st = 3; m_pend = 0; m_fph = 0;
      end else if (t) begin
        m_fph = !m_fph;
      end
    end else if (m_st == 3) begin
      m_st = 0; m_rem = RED_T; m_fph = 0;
    end else begin
      old = m_pend;
      if (pr && m_st != 0) m_pend = 1'b1;
      if (t) begin
        case (m_st)
          0: if (m_rem == 1) begin m_st = 1; m_rem = GRN_T; m_el = 0; end else m_rem--;
          1: begin
            m_el++;
            if (m_rem == 1 || (old && m_el >= MIN_GRN)) begin m_st = 2; m_rem = YEL_T; end
            else m_rem--;
          end
          default: if (m_rem == 1) begin
            m_st = 0; m_rem = RED_T; ack = old; m_pend = 1'b0;
          end else m_rem--;
        endcase
      end
    end
    case (m_st)
      0:       e.light = 3'b100;
      1:       e.light = 3'b010;
      2:       e.light = 3'b001;
      default: e.light = m_fph ? 3'b000 : 3'b001;
    endcase
    e.phase = 2'(m_st);
    e.ack   = ack;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Length of the current lamp state in clocks, counting the sample already shown.
  task automatic run_len(input logic [0:2] l, input int per, input logic pr, output int n);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      gk++;
      drive(1'b0, (gk % per) == 0, pr, 1'b0);
      if (light !== l) return;
      n++;
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    gk = 0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    gk = 0;
    checks++;
    if (light !== 3'b100 || phase !== 2'b00 || ped_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %b/%b/%b want 100/00/0", light, phase, ped_ack);
    end
  endtask

  task automatic test_free_run();
    int nr, ng, ny;
    nr = 0; ng = 0; ny = 0;
    for (int i = 0; i < 42; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      if (light === 3'b100) nr++;
      else if (light === 3'b010) ng++;
      else if (light === 3'b001) ny++;
    end
    checks++;
    if (nr != 20 || ng != 16 || ny != 6) begin
      errors++;
      $display("FAIL free_run_counts got R%0d G%0d Y%0d want R20 G16 Y6", nr, ng, ny);
    end
  endtask

  task automatic test_ped_early();
    int n;
    do_reset();
    run_len(3'b100, 1, 1'b0, n);
    checks++;
    if (n != RED_T) begin errors++; $display("FAIL ped_red_len got %0d want %0d", n, RED_T); end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    run_len(3'b010, 1, 1'b0, n);
    checks++;
    if (n + 2 != MIN_GRN) begin errors++; $display("FAIL ped_green_len got %0d want %0d", n + 2, MIN_GRN); end
    run_len(3'b001, 1, 1'b0, n);
    checks++;
    if (n != YEL_T) begin errors++; $display("FAIL ped_yel_len got %0d want %0d", n, YEL_T); end
    checks++;
    if (ped_ack !== 1'b1) begin errors++; $display("FAIL ped_ack_pulse got %b want 1", ped_ack); end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ped_ack !== 1'b0) begin errors++; $display("FAIL ped_ack_one_clk got %b want 0", ped_ack); end
    run_len(3'b100, 1, 1'b0, n);
    run_len(3'b010, 1, 1'b0, n);
    checks++;
    if (n != GRN_T) begin errors++; $display("FAIL ped_cleared_green got %0d want %0d", n, GRN_T); end
  endtask

  task automatic test_ped_ignored();
    int n;
    do_reset();
    run_len(3'b100, 1, 1'b1, n);
    run_len(3'b010, 1, 1'b0, n);
    checks++;
    if (n != GRN_T) begin errors++; $display("FAIL ign_green_len got %0d want %0d", n, GRN_T); end
    run_len(3'b001, 1, 1'b0, n);
    checks++;
    if (ped_ack !== 1'b0) begin errors++; $display("FAIL ign_ped_ack got %b want 0", ped_ack); end
  endtask

  task automatic test_tick_gating();
    int n;
    do_reset();
    run_len(3'b100, 4, 1'b0, n);
    checks++;
    if (n != 4 * RED_T) begin errors++; $display("FAIL gate_red_len got %0d want %0d", n, 4 * RED_T); end
    run_len(3'b010, 4, 1'b0, n);
    checks++;
    if (n != 4 * GRN_T) begin errors++; $display("FAIL gate_green_len got %0d want %0d", n, 4 * GRN_T); end
    do_reset();
    run_len(3'b100, 1, 1'b0, n);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (light !== 3'b010) begin errors++; $display("FAIL gate_freeze got %b want 010", light); end
    run_len(3'b010, 1, 1'b0, n);
    checks++;
    if (n != GRN_T - 1) begin errors++; $display("FAIL gate_resume_len got %0d want %0d", n, GRN_T - 1); end
  endtask

  task automatic test_flash();
    int n;
    do_reset();
    run_len(3'b100, 1, 1'b0, n);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (light !== 3'b001 || phase !== 2'b11) begin
      errors++; $display("FAIL flash_entry got %b/%b want 001/11", light, phase);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (light !== 3'b000) begin errors++; $display("FAIL flash_toggle got %b want 000", light); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (light !== 3'b100 || ped_ack !== 1'b0) begin
      errors++; $display("FAIL flash_exit got %b/%b want 100/0", light, ped_ack);
    end
    run_len(3'b100, 1, 1'b0, n);
    checks++;
    if (n != RED_T) begin errors++; $display("FAIL flash_red_len got %0d want %0d", n, RED_T); end
    run_len(3'b010, 1, 1'b0, n);
    run_len(3'b001, 1, 1'b0, n);
    checks++;
    if (ped_ack !== 1'b0) begin errors++; $display("FAIL flash_no_ack got %b want 0", ped_ack); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    run_len(3'b100, 1, 1'b0, n);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    run_len(3'b010, 1, 1'b0, n);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (light !== 3'b100 || phase !== 2'b00 || ped_ack !== 1'b0) begin
      errors++; $display("FAIL rst_in_yel got %b/%b/%b want 100/00/0", light, phase, ped_ack);
    end
    gk = 0;
    run_len(3'b100, 1, 1'b0, n);
    checks++;
    if (n != RED_T) begin errors++; $display("FAIL rst_yel_red_len got %0d want %0d", n, RED_T); end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (light !== 3'b100 || phase !== 2'b00 || ped_ack !== 1'b0) begin
      errors++; $display("FAIL rst_in_flash got %b/%b/%b want 100/00/0", light, phase, ped_ack);
    end
    gk = 0;
    run_len(3'b100, 1, 1'b0, n);
    checks++;
    if (n != RED_T) begin errors++; $display("FAIL rst_flash_red_len got %0d want %0d", n, RED_T); end
    run_len(3'b010, 1, 1'b0, n);
    run_len(3'b001, 1, 1'b0, n);
    checks++;
    if (ped_ack !== 1'b0) begin errors++; $display("FAIL rst_pend_cleared got %b want 0", ped_ack); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ped_early();
    test_ped_ignored();
    test_tick_gating();
    test_flash();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cyclic_lamp_ctrl.md
Name: cyclic_lamp_ctrl

Overview:
Programmable sequencer for the 3-lamp RGY signal head. It drives the lamp through RED -> GREEN -> YELLOW with per-phase durations counted in ticks, and shortens GREEN on a pedestrian request. It also supports a fault/maintenance flashing-yellow mode. It sits between the timing prescaler (tick source) and the lamp outputs, and replaces free-running cyclic lamp operation where timing control is needed.

Parameters:
CW, 8, width of phase tick counter
RED_T, 10, RED duration in ticks (1..2^CW)
GRN_T, 8, GREEN nominal duration in ticks (1..2^CW)
YEL_T, 3, YELLOW duration in ticks (1..2^CW)
MIN_GRN, 4, minimum GREEN ticks before a pedestrian request may cut GREEN short (1..GRN_T)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
tick  in  1  phase-time enable; all timing advances only on clocks where tick=1
ped_req  in  1  pedestrian request, level, sampled every clock
flash_en  in  1  flashing-yellow mode request, level
light  out  [0:2]  lamp drive: light[0]=R, light[1]=G, light[2]=Y (RGY order)
phase  out  2  current state: 00 RED, 01 GREEN, 10 YELLOW, 11 FLASH
ped_ack  out  1  one-clock pulse on entry to RED when a pedestrian request was pending

Behaviour:
- Clocking: single clock. Reset is synchronous and active-high. All outputs are registered and update on the same edge as the state register.
- Reset (rst=1 at an edge): state=RED, cnt=0, ped_pend=0, flash_ph=0, light=3'b100, phase=00, ped_ack=0. Reset overrides every other input, including mid-phase and in FLASH.
- cnt is an up-counter of CW bits. On a clock with tick=1 in RED/GREEN/YELLOW:
  - if cnt == T_phase-1, go to the next state and set cnt=0;
  - otherwise cnt=cnt+1.
- tick=0: state, cnt and flash_ph hold. ped_pend may still set.
- Transitions: RED -> GREEN after RED_T ticks; GREEN -> YELLOW after GRN_T ticks; YELLOW -> RED after YEL_T ticks.
- Each phase lasts exactly T ticks. With tick tied high, the full cycle is RED_T+GRN_T+YEL_T clocks (21 with defaults).
- Lamp encoding: RED 100, GREEN 010, YELLOW 001. Exactly one lamp is on in normal states.
- Pedestrian handling:
  - ped_pend sets on any clock with ped_req=1 while state is GREEN or YELLOW.
  - ped_req is ignored in RED and FLASH.
  - In GREEN with ped_pend=1, a tick with cnt >= MIN_GRN-1 forces GREEN -> YELLOW and sets cnt=0. GREEN is therefore at least MIN_GRN ticks long.
  - YELLOW is never shortened.
  - On the YELLOW -> RED edge: ped_ack=1 for that one clock if ped_pend=1, and ped_pend clears. ped_ack is 0 otherwise.
  - RED always runs the full RED_T.
- FLASH mode:
  - flash_en=1 at any clock (no tick needed) enters FLASH on that edge from any state, with cnt=0, flash_pend cleared (ped_pend=0) and flash_ph=0.
  - In FLASH, light = 001 when flash_ph=0 and 000 when flash_ph=1. flash_ph toggles on every tick.
  - flash_en=0 in FLASH exits to RED on that edge with cnt=0, so the full RED_T follows.
  - FLASH exit never pulses ped_ack.
- Priority at one edge: rst > flash_en > ped-forced exit > normal expiry > count.
- A pedestrian request coincident with GREEN's natural expiry gives the same YELLOW entry; ped_pend stays set and ped_ack fires at the next RED entry.
- Counter never exceeds T_phase-1. The FLASH -> RED and rst paths both force cnt=0, so no wrap-around is possible.

Test Plan:
- Free-run: rst high 2 clocks then low, tick=1, ped_req=0, flash_en=0 -> light=100 for 10 clocks, 010 for 8, 001 for 3, then 100 again. The period is 21 clocks and phase follows 00/01/10.
- Pedestrian early exit: pulse ped_req for 1 clock at GREEN cnt=1 -> GREEN lasts exactly 4 clocks, YELLOW 3. ped_ack=1 for exactly the clock RED is entered, then ped_pend clears (next cycle shows full 8-clock GREEN).
- Ignored request: ped_req=1 held throughout RED only -> no ped_pend, GREEN lasts the full 8 clocks, ped_ack stays 0.
- Tick gating: tick=1 every 4th clock -> each phase is 4x longer (RED 40 clocks). Holding tick=0 mid-GREEN freezes light=010 and cnt indefinitely.
- Flash: assert flash_en in mid-GREEN -> next edge light=001, then 000/001 alternating per tick. Deassert -> next edge light=100 with full 10-clock RED, and no ped_ack even if ped_req was set before flash.
- Reset mid-operation: assert rst during YELLOW with ped_pend=1, and separately during FLASH -> next edge light=100, phase=00, ped_ack=0. The sequence then restarts with a full 10-clock RED.
